random_point_gen: RTL and testbench

Parametrised pseudo-random point-set generator for the game logic. It produces N_POINTS on-screen (x, y) coordinates inside a margin-bounded playfield, using a deterministic, synthesizable 32-bit LFSR. A new set is generated on a periodic tick or on request. The whole set is committed atomically, so sprite and collision logic never sees a half-updated set.

---
 rtl/random_point_gen.sv | 182 ++++++++++++++++++
 tb/tb_random_point_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/random_point_gen.sv
// random_point_gen: LFSR-driven generator of N_POINTS playfield coordinates, committed as one atomic set.
// Optional spawn-area exclusion with bounded redraw is enabled by defining RANDOM_POINT_EXCL_EN.
module random_point_gen #(
  parameter int          N_POINTS  = 15,
  parameter int          COORD_W   = 11,
  parameter int          H_RES     = 1024,
  parameter int          V_RES     = 768,
  parameter int          MARGIN_LO = 5,
  parameter int          MARGIN_HI = 10,
  parameter int          PERIOD    = 65000000,
  parameter logic [31:0] SEED      = 32'hACE1_1234
`ifdef RANDOM_POINT_EXCL_EN
  ,
  parameter int          EXCL_X0   = 448,
  parameter int          EXCL_X1   = 576,
  parameter int          EXCL_Y0   = 320,
  parameter int          EXCL_Y1   = 448
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               regen_req,
  input  logic                               seed_load,
  input  logic [31:0]                        seed_in,
  output logic [N_POINTS-1:0][COORD_W-1:0]   position_x,
  output logic [N_POINTS-1:0][COORD_W-1:0]   position_y,
  output logic                               valid,
  output logic                               busy,
  output logic                               update_done
);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int SPAN_X  = H_RES - MARGIN_HI - MARGIN_LO + 1;
  localparam int SPAN_Y  = V_RES - MARGIN_HI - MARGIN_LO + 1;
  localparam int MUL_X_W = 16 + $clog2(SPAN_X);
  localparam int MUL_Y_W = 16 + $clog2(SPAN_Y);
  localparam int IDX_W   = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    GEN_X,
    GEN_Y,
`ifdef RANDOM_POINT_EXCL_EN
    CHECK,
`endif
    COMMIT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]        lfsr;
  logic [31:0]        lfsr_adv;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick;
  logic               trigger;
  logic               pending;
  logic               draw;
  logic [IDX_W-1:0]   idx;
  logic [MUL_X_W-1:0] prod_x;
  logic [MUL_Y_W-1:0] prod_y;
  logic [COORD_W-1:0] x_draw;
  logic [COORD_W-1:0] y_draw;
  logic [N_POINTS-1:0][COORD_W-1:0] work_x;
  logic [N_POINTS-1:0][COORD_W-1:0] work_y;

  // Draw path: advance once, then scale the upper half into the margin-bounded span.
  assign lfsr_adv = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
  assign prod_x   = MUL_X_W'(lfsr_adv[31:16]) * MUL_X_W'(SPAN_X);
  assign prod_y   = MUL_Y_W'(lfsr_adv[31:16]) * MUL_Y_W'(SPAN_Y);
  assign x_draw   = COORD_W'(MARGIN_LO) + COORD_W'(prod_x >> 16);
  assign y_draw   = COORD_W'(MARGIN_LO) + COORD_W'(prod_y >> 16);

  assign tick    = enable && (tick_cnt == CNT_LAST);
  assign trigger = tick || regen_req;

`ifdef RANDOM_POINT_EXCL_EN
  localparam int MAX_REJECT = 15;
  logic [3:0] retry;
  logic       in_box;
  logic       give_up;
  logic       accept;

  assign in_box  = (work_x[idx] >= COORD_W'(EXCL_X0)) && (work_x[idx] <= COORD_W'(EXCL_X1)) &&
                   (work_y[idx] >= COORD_W'(EXCL_Y0)) && (work_y[idx] <= COORD_W'(EXCL_Y1));
  assign give_up = (retry == 4'(MAX_REJECT - 1));
  assign accept  = !in_box || give_up;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (trigger) state_nxt = GEN_X;
      GEN_X:  state_nxt = GEN_Y;
`ifdef RANDOM_POINT_EXCL_EN
      GEN_Y:  state_nxt = CHECK;
      CHECK:  if (!accept)              state_nxt = GEN_X;
              else if (idx == LAST_IDX) state_nxt = COMMIT;
              else                      state_nxt = GEN_X;
`else
      GEN_Y:  state_nxt = (idx == LAST_IDX) ? COMMIT : GEN_X;
`endif
      COMMIT: state_nxt = (pending || trigger) ? GEN_X : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    update_done = (state == COMMIT);
    draw        = (state == GEN_X) || (state == GEN_Y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= SEED;
      tick_cnt   <= '0;
      pending    <= 1'b0;
      idx        <= '0;
      position_x <= '0;
      position_y <= '0;
      valid      <= 1'b0;
    end else begin
      // A zero seed would lock the LFSR, so it falls back to SEED.
      if (seed_load)  lfsr <= (seed_in == 32'h0) ? SEED : seed_in;
      else if (draw)  lfsr <= lfsr_adv;

      if (enable) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      // COMMIT consumes pending (and any same-cycle trigger) by restarting directly.
      if (state == COMMIT)       pending <= 1'b0;
      else if (busy && trigger)  pending <= 1'b1;

      case (state)
`ifdef RANDOM_POINT_EXCL_EN
        CHECK:   if (accept && idx != LAST_IDX) idx <= idx + 1'b1;
`else
        GEN_Y:   if (idx != LAST_IDX) idx <= idx + 1'b1;
`endif
        IDLE,
        COMMIT:  idx <= '0;
        default: ;
      endcase

      if (state == COMMIT) begin
        position_x <= work_x;
        position_y <= work_y;
        valid      <= 1'b1;
      end
    end
  end

  // NOTE: the working set is scratch storage fully rewritten before each commit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == GEN_X) work_x[idx] <= x_draw;
    if (state == GEN_Y) work_y[idx] <= y_draw;
`ifdef RANDOM_POINT_EXCL_EN
    if (state == CHECK && in_box && give_up) begin
      work_x[idx] <= COORD_W'(MARGIN_LO);
      work_y[idx] <= COORD_W'(MARGIN_LO);
    end
`endif
  end

`ifdef RANDOM_POINT_EXCL_EN
  always_ff @(posedge clk) begin
    if (rst || state == IDLE)        retry <= '0;
    else if (state == CHECK)         retry <= accept ? 4'd0 : retry + 4'd1;
  end
`endif

endmodule

// File: tb/tb_random_point_gen.sv
// Bench for random_point_gen: phase-counter reference model checked every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_random_point_gen;
  localparam int N      = 15;
  localparam int W      = 11;
  localparam int PERIOD = 100;
  localparam int SPAN_X = 1010;
  localparam int SPAN_Y = 754;
  localparam int RUN    = 2 * N + 1;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic clk = 1'b0;
  logic rst, enable, regen_req, seed_load;
  logic [31:0] seed_in;
  logic [N-1:0][W-1:0] position_x, position_y;
  logic valid, busy, update_done;

  random_point_gen #(.PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .regen_req(regen_req),
    .seed_load(seed_load), .seed_in(seed_in),
    .position_x(position_x), .position_y(position_y),
    .valid(valid), .busy(busy), .update_done(update_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_set(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [W-1:0] map_c(input logic [31:0] s, input int span);
    longint r;
    r = longint'(s[31:16]);
    return W'(5 + (r * span) / 65536);
  endfunction

  function automatic void gen_set(input logic [31:0] seed,
                                  output logic [N-1:0][W-1:0] gx, output logic [N-1:0][W-1:0] gy);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < N; i++) begin
      s = lfsr_step(s); gx[i] = map_c(s, SPAN_X);
      s = lfsr_step(s); gy[i] = map_c(s, SPAN_Y);
    end
  endfunction

  // Model: m_phase counts cycles into a run (0 = idle, RUN = commit cycle).
  logic [31:0] m_lfsr, m_adv;
  int          m_phase, m_cnt, m_k;
  bit          m_pending, m_valid, m_live = 1'b0, m_tick, m_trig;
  logic [N-1:0][W-1:0] m_px, m_py, m_wx, m_wy;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_live = 1'b1; m_lfsr = SEED; m_phase = 0; m_pending = 1'b0;
      m_cnt = 0; m_valid = 1'b0; m_px = '0; m_py = '0;
    end else if (m_live) begin
      m_tick = enable && (m_cnt == PERIOD - 1);
      if (enable) m_cnt = m_tick ? 0 : m_cnt + 1;
      m_trig = m_tick || regen_req;
      m_adv  = lfsr_step(m_lfsr);
      if (m_phase >= 1 && m_phase <= 2 * N) begin
        m_k = (m_phase - 1) / 2;
        if ((m_phase - 1) % 2 == 0) m_wx[m_k] = map_c(m_adv, SPAN_X);
        else                        m_wy[m_k] = map_c(m_adv, SPAN_Y);
        m_lfsr = m_adv;
      end
      if (seed_load) m_lfsr = (seed_in == 32'h0) ? SEED : seed_in;
      if (m_phase == RUN) begin
        m_px = m_wx; m_py = m_wy; m_valid = 1'b1;
        m_phase = (m_pending || m_trig) ? 1 : 0;
        m_pending = 1'b0;
      end else if (m_phase == 0) begin
        m_phase = m_trig ? 1 : 0;
      end else begin
        m_phase++;
        if (m_trig) m_pending = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (update_done === 1'b1) done_q.push_back(cyc);
    if (m_live) begin
      check("busy", busy, 64'(m_phase != 0));
      check("update_done", update_done, 64'(m_phase == RUN));
      check("valid", valid, 64'(m_valid));
      check_set("position_x", position_x, m_px);
      check_set("position_y", position_y, m_py);
    end
  end

  task automatic pulse_regen(output int c0);
    @(posedge clk); #1 regen_req = 1'b1; c0 = cyc;
    @(posedge clk); #1 regen_req = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    @(posedge clk); #1 seed_load = 1'b1; seed_in = s;
    @(posedge clk); #1 seed_load = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    for (int i = 0; i < budget && done_q.size() < n; i++) @(posedge clk);
    check("done_within_budget", 64'(done_q.size() >= n), 64'd1);
  endtask

  task automatic regen_and_wait();
    int c0, n;
    n = done_q.size();
    pulse_regen(c0);
    wait_dones(n + 1, 60);
    @(negedge clk);
  endtask

  initial begin
    int c0, nbusy, tdone, n, e;
    logic [N-1:0][W-1:0] gx, gy;
    rst = 1'b1; enable = 1'b0; regen_req = 1'b0; seed_load = 1'b0; seed_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_update_done", update_done, 0);
    check_set("rst_position_x", position_x, '0);
    check_set("rst_position_y", position_y, '0);
    check("rst_lfsr", dut.lfsr, 64'(SEED));

    // Reset in the middle of a run aborts it.
    pulse_regen(c0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check_set("midrst_position_x", position_x, '0);

    // Single regeneration from the reset seed.
    pulse_regen(c0);
    nbusy = 0; tdone = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
      if (update_done === 1'b1 && tdone < 0) tdone = cyc;
    end
    check("regen_busy_cycles", 64'(nbusy), 64'd31);
    check("regen_latency", 64'(tdone - c0), 64'd31);
    check("regen_valid", valid, 1);
    check("pin_x0", position_x[0], 64'd346);
    check("pin_y0", position_y[0], 64'd132);
    check("pin_x1", position_x[1], 64'd595);
    for (int i = 0; i < N; i++) begin
      check("x_in_range", 64'(position_x[i] >= 5 && position_x[i] <= 1014), 64'd1);
      check("y_in_range", 64'(position_y[i] >= 5 && position_y[i] <= 758), 64'd1);
    end
    gen_set(SEED, gx, gy);
    check_set("reset_seed_set_x", position_x, gx);
    check_set("reset_seed_set_y", position_y, gy);

    // Seed loading: repeatable sets, zero falls back to SEED.
    gen_set(32'h1234_5678, gx, gy);
    load_seed(32'h1234_5678);
    regen_and_wait();
    check_set("seed_a_x", position_x, gx);
    check_set("seed_a_y", position_y, gy);
    load_seed(32'h1234_5678);
    regen_and_wait();
    check_set("seed_a_again_x", position_x, gx);
    check_set("seed_a_again_y", position_y, gy);
    load_seed(32'h0);
    regen_and_wait();
    gen_set(SEED, gx, gy);
    check_set("seed_zero_x", position_x, gx);
    check_set("seed_zero_y", position_y, gy);
    check("seed_zero_pin_x0", position_x[0], 64'd346);

    // Three requests during one run collapse into one extra run.
    n = done_q.size();
    pulse_regen(c0);
    repeat (4) @(posedge clk);
    pulse_regen(e);
    repeat (4) @(posedge clk);
    pulse_regen(e);
    repeat (100) @(posedge clk);
    check("collapse_count", 64'(done_q.size() - n), 64'd2);
    if (done_q.size() >= n + 2) begin
      check("collapse_first", 64'(done_q[n] - c0), 64'd31);
      check("collapse_second", 64'(done_q[n+1] - done_q[n]), 64'd31);
    end

    // Periodic tick, then a 50-cycle enable pause stretches one interval.
    n = done_q.size();
    @(posedge clk); #1 enable = 1'b1; e = cyc;
    wait_dones(n + 3, 400);
    if (done_q.size() >= n + 3) begin
      check("tick_first", 64'(done_q[n] - e), 64'd130);
      check("tick_spacing", 64'(done_q[n+2] - done_q[n+1]), 64'd100);
    end
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    repeat (50) @(posedge clk);
    #1 enable = 1'b1;
    wait_dones(n + 4, 300);
    if (done_q.size() >= n + 4)
      check("tick_paused_spacing", 64'(done_q[n+3] - done_q[n+2]), 64'd150);
    @(posedge clk); #1 enable = 1'b0;
    repeat (40) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
